// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit for the 16-bit TSC-style CPU core.
// Define MC_CTRL_PERF_EN to add the cycle_cnt/stall_cnt performance counters.
module mc_ctrl_fsm #(
    parameter int WORD_SIZE   = 16,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] mem_data_in,
    input  logic                 mem_ready,
    input  logic                 bcond,
    output logic [WORD_SIZE-1:0] ir,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           wb_sel,
    output logic                 alu_src_b,
    output logic                 ext_sign,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 out_en,
    output logic [CNT_W-1:0]     num_inst,
    output logic                 is_halted,
`ifdef MC_CTRL_PERF_EN
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
`endif
    output logic                 bus_err
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    typedef enum logic [3:0] {
        C_NOP, C_BRANCH, C_ADI, C_ORI, C_LHI, C_LWD, C_SWD,
        C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_ALU
    } iclass_t;

    state_t              state;
    state_t              next_state;
    iclass_t             iclass;
    logic [3:0]          opcode;
    logic [5:0]          funct;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                timeout_hit;
    logic                timeout;
    logic                retire;

    assign opcode      = ir[WORD_SIZE-1 -: 4];
    assign funct       = ir[5:0];
    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        iclass = C_NOP;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3: iclass = C_BRANCH;
            4'd4:  iclass = C_ADI;
            4'd5:  iclass = C_ORI;
            4'd6:  iclass = C_LHI;
            4'd7:  iclass = C_LWD;
            4'd8:  iclass = C_SWD;
            4'd9:  iclass = C_JMP;
            4'd10: iclass = C_JAL;
            4'd15: begin
                if (funct < 6'd8) begin
                    iclass = C_ALU;
                end else begin
                    case (funct)
                        6'd25:   iclass = C_JPR;
                        6'd26:   iclass = C_JRL;
                        6'd28:   iclass = C_WWD;
                        6'd29:   iclass = C_HLT;
                        default: iclass = C_NOP;
                    endcase
                end
            end
            default: iclass = C_NOP;
        endcase
    end

    // Strobes decode state/ir (plus the handshake inputs) and are forced low while Reset is held.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        next_state = state;
        retire     = 1'b0;
        timeout    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        alu_src_b  = 1'b0;
        ext_sign   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        out_en     = 1'b0;
        if (!Reset) begin
            case (state)
                S_IF: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        next_state = S_ID;
                    end else if (timeout_hit) begin
                        timeout    = 1'b1;
                        next_state = S_HALT;
                    end
                end
                S_ID: begin
                    next_state = S_IF;
                    retire     = 1'b1;
                    case (iclass)
                        C_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                        end
                        C_JAL, C_JRL: begin
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_sel    = 2'd2;
                            pc_write  = 1'b1;
                            pc_src    = (iclass == C_JAL) ? 2'd2 : 2'd3;
                        end
                        C_JPR: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd3;
                        end
                        C_WWD: begin
                            out_en   = 1'b1;
                            pc_write = 1'b1;
                        end
                        C_NOP: pc_write = 1'b1;
                        C_HLT: next_state = S_HALT;
                        default: begin
                            next_state = S_EX;
                            retire     = 1'b0;
                        end
                    endcase
                end
                S_EX: begin
                    case (iclass)
                        C_BRANCH: begin
                            pc_write   = 1'b1;
                            pc_src     = {1'b0, bcond};
                            ext_sign   = 1'b1;
                            next_state = S_IF;
                            retire     = 1'b1;
                        end
                        C_LWD, C_SWD: begin
                            alu_src_b  = 1'b1;
                            ext_sign   = 1'b1;
                            next_state = S_MEM;
                        end
                        C_ADI, C_LHI: begin
                            alu_src_b  = 1'b1;
                            ext_sign   = 1'b1;
                            next_state = S_WB;
                        end
                        C_ORI: begin
                            alu_src_b  = 1'b1;
                            next_state = S_WB;
                        end
                        C_ALU:   next_state = S_WB;
                        default: next_state = S_IF;
                    endcase
                end
                S_MEM: begin
                    mem_read  = (iclass == C_LWD);
                    mem_write = (iclass != C_LWD);
                    if (mem_ready) begin
                        if (iclass == C_LWD) begin
                            next_state = S_WB;
                        end else begin
                            pc_write   = 1'b1;
                            next_state = S_IF;
                            retire     = 1'b1;
                        end
                    end else if (timeout_hit) begin
                        timeout    = 1'b1;
                        next_state = S_HALT;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    wb_sel     = (iclass == C_LWD) ? 2'd1 : 2'd0;
                    reg_dst    = (iclass == C_ALU) ? 2'd1 : 2'd0;
                    pc_write   = 1'b1;
                    next_state = S_IF;
                    retire     = 1'b1;
                end
                default: next_state = S_HALT;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (Reset) begin
            state     <= S_IF;
            ir        <= '0;
            num_inst  <= '0;
            is_halted <= 1'b0;
            bus_err   <= 1'b0;
            wait_cnt  <= '0;
`ifdef MC_CTRL_PERF_EN
            cycle_cnt <= '0;
            stall_cnt <= '0;
`endif
        end else begin
            state <= next_state;
            if (ir_write) ir <= mem_data_in;
            if (retire) num_inst <= num_inst + 1'b1;
            if (next_state == S_HALT) is_halted <= 1'b1;
            if (timeout) bus_err <= 1'b1;
            // The wait counter restarts on every state change and on every completed access.
            if (mem_ready || next_state != state) begin
                wait_cnt <= '0;
            end else if ((state == S_IF || state == S_MEM) && MEM_TIMEOUT > 0) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
`ifdef MC_CTRL_PERF_EN
            if (state != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
            if ((state == S_IF || state == S_MEM) && !mem_ready) stall_cnt <= stall_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the 16-bit TSC-style CPU core.
- Sequences every instruction through IF/ID/EX/MEM/WB, holding the instruction register (IR) and the retired-instruction counter.
- Drives the datapath control strobes and waits on a memory-ready handshake, so variable-latency memory is supported.
- Sits between the memory interface and the datapath (ALU, register file, PC register) inside cpu.

Parameters:
WORD_SIZE, 16, instruction/data word width; opcode is always the top 4 bits.
CNT_W, 16, width of num_inst.
MEM_TIMEOUT, 0, max wait cycles for mem_ready before bus error; 0 disables the timeout.

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous active-high reset
mem_data_in  in  WORD_SIZE  memory read data, sampled into IR in IF
mem_ready  in  1  memory access complete this cycle
bcond  in  1  ALU branch-condition result, valid in EX
ir  out  WORD_SIZE  latched instruction
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  1 = address from PC, 0 = address from ALU result
ir_write  out  1  IR load strobe
reg_write  out  1  register file write strobe
reg_dst  out  2  0 = rt [9:8], 1 = rd [7:6], 2 = r2
wb_sel  out  2  0 = ALU, 1 = memory, 2 = PC+1
alu_src_b  out  1  0 = register B, 1 = extended immediate
ext_sign  out  1  1 = sign-extend imm[7:0], 0 = zero-extend
pc_write  out  1  PC update strobe
pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump {PC[15:12],ir[11:0]}, 3 = register rs
out_en  out  1  output_port load strobe (WWD)
num_inst  out  CNT_W  retired instruction count
is_halted  out  1  sticky halt
bus_err  out  1  sticky memory-timeout flag

Behaviour:
- Decode fields: opcode ir[15:12], funct ir[5:0].
  - Opcodes: 0 BNE, 1 BEQ, 2 BGZ, 3 BLZ, 4 ADI, 5 ORI, 6 LHI, 7 LWD, 8 SWD, 9 JMP, 10 JAL, 15 R-type.
  - R-type funct: 0..7 ALU, 25 JPR, 26 JRL, 28 WWD, 29 HLT.
- Reset:
  - state = IF; ir = 0; num_inst = 0; is_halted = 0; bus_err = 0; wait counter = 0.
  - All strobes are combinational decodes of state and ir, and therefore 0 during reset.
- States: IF, ID, EX, MEM, WB, HALT.
- IF:
  - mem_read = 1, iord = 1.
  - On mem_ready: ir_write = 1, IR loads mem_data_in, go to ID. Otherwise stay in IF.
- ID:
  - JMP: pc_write, pc_src = 2, go to IF.
  - JAL: reg_write, reg_dst = 2, wb_sel = 2, pc_write, pc_src = 2, go to IF.
  - JPR: pc_write, pc_src = 3, go to IF.
  - JRL: the JAL strobes but with pc_src = 3, go to IF.
  - WWD: out_en, pc_write, pc_src = 0, go to IF.
  - HLT: go to HALT.
  - Undefined opcode or funct: pc_write, pc_src = 0, go to IF (NOP).
  - All other instructions: go to EX.
- EX:
  - Branch: pc_write, pc_src = bcond ? 1 : 0, ext_sign = 1, alu_src_b = 0, go to IF.
  - LWD/SWD: alu_src_b = 1, ext_sign = 1, go to MEM.
  - ADI/LHI: alu_src_b = 1, ext_sign = 1, go to WB.
  - ORI: alu_src_b = 1, ext_sign = 0, go to WB.
  - R-type ALU: alu_src_b = 0, go to WB.
- MEM:
  - iord = 0.
  - LWD: mem_read = 1; on mem_ready go to WB.
  - SWD: mem_write = 1; on mem_ready: pc_write, pc_src = 0, go to IF.
- WB:
  - reg_write, wb_sel = LWD ? 1 : 0, reg_dst = R-type ? 1 : 0.
  - pc_write, pc_src = 0, go to IF.
- Retirement:
  - num_inst increments by 1 in the cycle leaving the final state of each instruction, including WWD, NOP and HLT.
  - num_inst wraps modulo 2^CNT_W.
  - Exactly one increment per instruction.
- HALT:
  - is_halted = 1; all strobes 0; state held until Reset.
- Memory timeout (MEM_TIMEOUT > 0):
  - The wait counter clears on entry to IF/MEM and on mem_ready.
  - It increments each cycle without mem_ready.
  - On reaching MEM_TIMEOUT: bus_err = 1, go to HALT, no retire.
- Simultaneous events:
  - Reset overrides everything, including mid-MEM and HALT.
  - mem_ready in the same cycle as timeout expiry counts as success.
  - mem_ready outside IF/MEM is ignored.
- Latency with mem_ready always high: JMP/JAL/JPR/JRL/WWD 2 cycles; branch 3; ALU 4; SWD 4; LWD 5.

Optional Feature:
MC_CTRL_PERF_EN
- Defined: adds outputs cycle_cnt (CNT_W) and stall_cnt (CNT_W), both reset to 0.
  - cycle_cnt increments every non-HALT cycle.
  - stall_cnt increments every IF/MEM cycle with mem_ready = 0.
  - Both wrap modulo 2^CNT_W.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset asserted 3 cycles, then fetch ADI (0x4101) with mem_ready tied 1 -> state IF, ID, EX, WB; reg_write pulse in cycle 4 with reg_dst = 0, wb_sel = 0; num_inst = 1.
- BEQ with bcond = 1, then BEQ with bcond = 0 -> pc_src = 1 then 0 in EX; each takes 3 cycles; num_inst = 2.
- LWD with mem_ready low 4 cycles in MEM -> mem_read held through 4 extra cycles; WB has wb_sel = 1; total 9 cycles.
- JAL 0xA123 -> in ID: reg_write = 1, reg_dst = 2, wb_sel = 2, pc_src = 2; 2 cycles total.
- HLT (0xF01D), then 10 more cycles -> is_halted = 1, all strobes 0, num_inst frozen; Reset returns state to IF and num_inst to 0.
- MEM_TIMEOUT = 8, mem_ready held 0 in IF -> bus_err = 1 and is_halted = 1 after 8 wait cycles; num_inst unchanged.
